// File: rtl/pe_pkg.sv
// Shared PE definitions: mode and FSM encodings plus the saturating/sign-extend
// helpers that the pooling unit will reuse.
package pe_pkg;
   localparam int XW = 64;  // working width for helpers; callers truncate to their own PW

   typedef enum logic [1:0] {
      MODE_MAC = 2'b00,
      MODE_SUM = 2'b01,
      MODE_MAX = 2'b10,
      MODE_RSV = 2'b11
   } modeT;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      ISSUE = 2'b01,
      DRAIN = 2'b10
   } stateT;

   // Treat the low w bits of v as signed and extend to XW.
   function automatic logic signed [XW-1:0] sext(input logic [XW-1:0] v, input int w);
      logic signed [XW-1:0] t;
      t = v << (XW - w);
      return t >>> (XW - w);
   endfunction

   // a+b clamped to the signed pw-bit range; a and b must already lie in that range.
   function automatic logic signed [XW-1:0] satAdd(input logic signed [XW-1:0] a,
                                                   input logic signed [XW-1:0] b,
                                                   input int pw);
      logic signed [XW-1:0] one, hi, lo, s;
      one = XW'(1);
      hi  = (one <<< (pw - 1)) - one;
      lo  = ~hi;
      s   = a + b;
      if (s > hi) return hi;
      if (s < lo) return lo;
      return s;
   endfunction
endpackage

// File: rtl/pe_local_store.sv
// Single-write, synchronous-read local store; a same-cycle read of the written
// address returns the old word.
module pe_local_store #(
   parameter int W = 16,
   parameter int A = 7
) (
   input  logic         CLK,
   input  logic         wrEn,
   input  logic [A-1:0] wrAddr,
   input  logic [W-1:0] wrData,
   input  logic [A-1:0] rdAddr,
   output logic [W-1:0] rdData
);
   logic [W-1:0] mem [2**A];

   always_ff @(posedge CLK) begin
      if (wrEn) mem[wrAddr] <= wrData;
      rdData <= mem[rdAddr];
   end
endmodule

// File: rtl/pe_mac_pipelined.sv
// Systolic PE: self-addressed MAC / sum-pool / max-pool over a base/stride/length
// descriptor, seeded with the upstream partial sum.
module pe_mac_pipelined
   import pe_pkg::*;
#(
   parameter int W  = 16,
   parameter int A  = 7,
   parameter int PW = 40
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 kWrEn,
   input  logic [A-1:0]         kWrAddr,
   input  logic [W-1:0]         kWrData,
   input  logic                 nWrEn,
   input  logic [A-1:0]         nWrAddr,
   input  logic [W-1:0]         nWrData,
   input  logic                 start,
   input  logic [A:0]           len,
   input  logic [A-1:0]         kBase,
   input  logic [A-1:0]         nBase,
   input  logic [A-1:0]         nStride,
   input  logic [1:0]           mode,
   input  logic signed [PW-1:0] psumIn,
   output logic signed [PW-1:0] psumOut,
   output logic                 psumOutValid,
   output logic                 busy
);
   stateT              state, stateNxt;
   modeT               modeR;
   logic [A:0]         lenR, stepCnt;
   logic [A-1:0]       kAddr, nAddr, nStrideR;
   logic [2:1]         vldPipe;   // [1] store data ready, [2] operand ready
   logic [3:1]         lastPipe;  // end-of-descriptor token trailing the last step
   logic               accept, issueVld, lastIssue;
   logic signed [W-1:0]    kRd, nRd;
   logic signed [2*W-1:0]  prod;
   logic signed [PW-1:0]   opReg, opNext, acc, accNext;
   logic signed [XW-1:0]   accX, opX;

   pe_local_store #(.W(W), .A(A)) uKStore (
      .CLK(CLK), .wrEn(kWrEn), .wrAddr(kWrAddr), .wrData(kWrData),
      .rdAddr(kAddr), .rdData(kRd)
   );

   pe_local_store #(.W(W), .A(A)) uNStore (
      .CLK(CLK), .wrEn(nWrEn), .wrAddr(nWrAddr), .wrData(nWrData),
      .rdAddr(nAddr), .rdData(nRd)
   );

   assign accept    = start && (state == IDLE);
   assign issueVld  = (state == ISSUE);
   assign lastIssue = issueVld && (stepCnt == lenR - (A+1)'(1));
   assign busy      = (state != IDLE);
   assign prod      = kRd * nRd;

   always_comb begin
      stateNxt = state;
      case (state)
         IDLE:    if (start) stateNxt = (len == '0) ? DRAIN : ISSUE;
         ISSUE:   if (lastIssue) stateNxt = DRAIN;
         DRAIN:   if (lastPipe[3]) stateNxt = IDLE;
         default: stateNxt = IDLE;
      endcase
   end

   // Reserved mode falls through to MAC.
   always_comb begin
      opNext = PW'(sext({{(XW-2*W){1'b0}}, prod}, 2*W));
      if (modeR == MODE_SUM || modeR == MODE_MAX)
         opNext = PW'(sext({{(XW-W){1'b0}}, nRd}, W));
      accX    = sext({{(XW-PW){1'b0}}, acc}, PW);
      opX     = sext({{(XW-PW){1'b0}}, opReg}, PW);
      accNext = PW'(satAdd(accX, opX, PW));
      if (modeR == MODE_MAX) accNext = (opX > accX) ? opReg : acc;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state        <= IDLE;
         modeR        <= MODE_MAC;
         lenR         <= '0;
         stepCnt      <= '0;
         kAddr        <= '0;
         nAddr        <= '0;
         nStrideR     <= '0;
         vldPipe      <= '0;
         lastPipe     <= '0;
         opReg        <= '0;
         acc          <= '0;
         psumOut      <= '0;
         psumOutValid <= 1'b0;
      end else begin
         state        <= stateNxt;
         vldPipe      <= {vldPipe[1], issueVld};
         lastPipe     <= {lastPipe[2:1], (accept && len == '0) || lastIssue};
         psumOutValid <= lastPipe[3];
         if (lastPipe[3]) psumOut <= acc;
         if (vldPipe[1]) opReg <= opNext;
         if (accept) begin
            lenR     <= len;
            kAddr    <= kBase;
            nAddr    <= nBase;
            nStrideR <= nStride;
            modeR    <= modeT'(mode);
            stepCnt  <= '0;
            acc      <= psumIn;
         end else begin
            if (issueVld) begin
               kAddr   <= kAddr + A'(1);
               nAddr   <= nAddr + nStrideR;
               stepCnt <= stepCnt + (A+1)'(1);
            end
            if (vldPipe[2]) acc <= accNext;
         end
      end
   end
endmodule

// File: doc/pe_mac_pipelined.md
Name: pe_mac_pipelined

Overview:
- Next-generation processing element for the systolic CNN array.
- Holds private kernel and neuron local stores and generates its own read addresses from a base/stride/length descriptor, so no external per-cycle controller is needed.
- Runs a pipelined, saturating multiply-accumulate (or sum/max pooling) over the descriptor, seeded with the upstream partial sum.
- Emits the result with a one-cycle valid pulse; the next PE in the column chains from it.

Parameters:
- W, 16: kernel/neuron word width, signed two's complement.
- A, 7: local-store address width; each store holds 2^A words.
- PW, 40: partial-sum width, signed; legal range PW >= 2*W.

Ports:
- CLK  in  1  clock, all state on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- kWrEn  in  1  kernel store write enable.
- kWrAddr  in  A  kernel store write address.
- kWrData  in  W  kernel store write data.
- nWrEn  in  1  neuron store write enable.
- nWrAddr  in  A  neuron store write address.
- nWrData  in  W  neuron store write data.
- start  in  1  descriptor valid; accepted only when busy=0.
- len  in  A+1  number of MAC steps, 0..2^A.
- kBase  in  A  first kernel address.
- nBase  in  A  first neuron address.
- nStride  in  A  neuron address increment per step.
- mode  in  2  00 MAC, 01 SUM-pool, 10 MAX-pool, 11 reserved (treated as MAC).
- psumIn  in  PW  upstream partial sum, sampled with start.
- psumOut  out  PW  result.
- psumOutValid  out  1  one-cycle result strobe.
- busy  out  1  descriptor in progress.

Behaviour:
- Reset (asynchronous, any time including mid-run):
  - FSM returns to IDLE.
  - psumOut=0, psumOutValid=0, busy=0; pipeline valids, counters and accumulator cleared.
  - Store contents are not reset; they are undefined after power-up and retained across RST.
- FSM states IDLE, ISSUE, DRAIN.
  - IDLE: start=1 on edge E0 latches len, kBase, nBase, nStride, mode; acc <= psumIn; busy=1. Next state is ISSUE, or DRAIN if len=0.
  - ISSUE: step i=0..len-1, one per cycle. Read addresses kAddr=(kBase+i) mod 2^A, nAddr=(nBase+i*nStride) mod 2^A; both wrap silently. Leaves after the step with i=len-1.
  - DRAIN: waits for the pipeline to empty, then returns to IDLE.
- Pipeline per step:
  - P0: address issue.
  - P1: synchronous store read.
  - P2: registered product/operand.
  - P3: accumulate.
- Latency:
  - psumOutValid is high exactly in the cycle after edge E0+len+3.
  - For len=0 it is high after edge E0+3, with psumOut=psumIn.
  - busy falls on that same edge.
  - A new start in that cycle is accepted; back-to-back descriptors therefore have a 0-cycle gap.
- start while busy=1 is ignored; no queuing.
- psumOut holds its value until the next result; psumOutValid is a single-cycle pulse.
- Arithmetic:
  - MAC: product = kWord*nWord signed, 2W bits, sign-extended to PW; acc = sat(acc+product).
  - SUM: acc = sat(acc + sext(nWord)); kernel store is read but ignored.
  - MAX: acc = max(acc, sext(nWord)), signed compare.
  - sat clamps to [-2^(PW-1), 2^(PW-1)-1]. Once clamped, later steps continue from the clamped value; no sticky flag.
- Store port behaviour:
  - Writes are legal at any time, including while busy.
  - A same-cycle write and read to one address returns old data (read-before-write).
  - Write ports are independent of the FSM.

Decomposition:
- Shared package pe_pkg holds:
  - mode encodings (MODE_MAC, MODE_SUM, MODE_MAX);
  - FSM state encodings;
  - the sat/sign-extend helper functions, shared with the future pooling unit.
- Sub-module pe_local_store:
  - parametrised W/A synchronous-read, single-write RAM with read-before-write;
  - instanced twice, once for kernels and once for neurons.

Test Plan:
- MAC basic: kernel[0..3]={1,2,3,4}, neuron[0..3]={5,6,7,8}; start len=4, kBase=0, nBase=0, nStride=1, psumIn=10, mode=00 -> psumOutValid one cycle, 7 cycles after start edge; psumOut=80; busy low same edge.
- Stride/wrap (A=7): nBase=126, nStride=3, len=3, neuron[126]=2, neuron[1]=3, neuron[4]=4, kernel[0..2]=1, psumIn=0 -> psumOut=9 (addresses 126, 1, 4).
- Pooling: neuron={-5,9,-2} at 0..2, psumIn=-100. mode=10 -> 9. mode=01 with psumIn=0 -> 2.
- Saturation (W=16, PW=40): psumIn=2^39-10, kernel=neuron=32767 (x2 steps, MAC) -> psumOut=2^39-1. Negative twin: psumIn=-2^39+5, kernel=-32768, neuron=32767 -> -2^39.
- Handshake/edge: len=0, psumIn=42 -> valid 3 cycles later with 42. A start asserted while busy is ignored. A new start in the valid cycle is accepted, and its result appears len+3 cycles later.
- Reset mid-run: assert RST during ISSUE -> psumOut=0, busy=0, no valid pulse; store contents intact on rerun with identical result.
